// File: rtl/lzc_pipe_if.sv
// lzc_pipe_if: operand/result handshake bundle for lzc_pipe; in_trail exists only with LZC_PIPE_CTZ_EN
interface lzc_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int OUT_W = 32
);
  logic in_valid, in_ready, in_ones, flush, out_valid, out_ready, busy;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [OUT_W-1:0] out_count;
`ifdef LZC_PIPE_CTZ_EN
  logic in_trail;
`endif
  modport master (
    output in_valid, in_data, in_ones, in_tag, flush, out_ready,
`ifdef LZC_PIPE_CTZ_EN
    output in_trail,
`endif
    input in_ready, out_valid, out_count, out_tag, busy
  );
  modport slave (
    input in_valid, in_data, in_ones, in_tag, flush, out_ready,
`ifdef LZC_PIPE_CTZ_EN
    input in_trail,
`endif
    output in_ready, out_valid, out_count, out_tag, busy
  );
endinterface

// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined leading zero/one counter with valid/ready, tag and flush; LZC_PIPE_CTZ_EN adds trailing counts
module lzc_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2,
  parameter int TAG_W = 5,
  parameter int OUT_W = 32
) (
  input logic clk,
  input logic rst,
  lzc_pipe_if.slave bus
);
  localparam int L = $clog2(WIDTH);
  localparam int LO = L / 2;
  localparam int RW = 1 << LO;
  localparam int STOP = (STAGES == 2) ? LO : 0;
  logic [WIDTH-1:0] v, x;
  logic [L-1:STOP] cnt1;
  logic take;
`ifdef LZC_PIPE_CTZ_EN
  logic [WIDTH-1:0] rev;
  assign rev = {<<{bus.in_data}};
  assign v = (bus.in_trail ? rev : bus.in_data) ^ {WIDTH{bus.in_ones}};
`else
  assign v = bus.in_data ^ {WIDTH{bus.in_ones}};
`endif
  assign take = bus.in_valid & bus.in_ready;
  always_comb begin
    x = v;
    cnt1 = '0;
    for (int i = L - 1; i >= STOP; i--) begin
      cnt1[i] = ~|(x >> (WIDTH - (1 << i)));
      x = cnt1[i] ? x << (1 << i) : x;
    end
  end
  generate
    if (STAGES == 1) begin : g_one
      logic vld, zero;
      logic [OUT_W-1:0] cnt_q;
      logic [TAG_W-1:0] tag_q;
      assign zero = ~|v;
      assign bus.in_ready = (!vld | bus.out_ready) & !bus.flush;
      assign bus.out_valid = vld;
      assign bus.out_count = cnt_q;
      assign bus.out_tag = tag_q;
      assign bus.busy = vld;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= 1'b0;
          cnt_q <= '0;
          tag_q <= '0;
        end else begin
          vld <= bus.flush ? 1'b0 : (!vld | bus.out_ready) ? take : vld;
          if (take) begin
            cnt_q <= OUT_W'({zero, zero ? L'(0) : cnt1});
            tag_q <= bus.in_tag;
          end
        end
      end
    end else begin : g_two
      logic v1, v2, rdy1, rdy2, zero;
      logic [WIDTH-1:0] v_q;
      logic [TAG_W-1:0] tag1, tag2;
      logic [L-1:LO] hi_q;
      logic [RW-1:0] res_q, y;
      logic [LO-1:0] cnt2;
      logic [OUT_W-1:0] cnt_q;
      assign rdy2 = !v2 | bus.out_ready;
      assign rdy1 = !v1 | rdy2;
      assign zero = ~|v_q;
      assign bus.in_ready = rdy1 & !bus.flush;
      assign bus.out_valid = v2;
      assign bus.out_count = cnt_q;
      assign bus.out_tag = tag2;
      assign bus.busy = v1 | v2;
      always_comb begin
        y = res_q;
        cnt2 = '0;
        for (int i = LO - 1; i >= 0; i--) begin
          cnt2[i] = ~|(y >> (RW - (1 << i)));
          y = cnt2[i] ? y << (1 << i) : y;
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v1 <= 1'b0;
          v2 <= 1'b0;
          v_q <= '0;
          tag1 <= '0;
          tag2 <= '0;
          hi_q <= '0;
          res_q <= '0;
          cnt_q <= '0;
        end else begin
          v1 <= bus.flush ? 1'b0 : rdy1 ? take : v1;
          v2 <= bus.flush ? 1'b0 : rdy2 ? v1 : v2;
          if (take) begin
            v_q <= v;
            tag1 <= bus.in_tag;
            hi_q <= cnt1;
            res_q <= x[WIDTH-1 -: RW];
          end
          if (rdy2 & v1) begin
            cnt_q <= OUT_W'({zero, zero ? L'(0) : {hi_q, cnt2}});
            tag2 <= tag1;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: directed checks of lzc_pipe at 32-bit/2-stage and 64-bit/1-stage
module tb_lzc_pipe;
  logic clk, rst;
  int checks, failures;
  lzc_pipe_if #(.WIDTH(32), .TAG_W(5), .OUT_W(32)) a ();
  lzc_pipe_if #(.WIDTH(64), .TAG_W(5), .OUT_W(32)) b ();
  lzc_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5), .OUT_W(32)) u32 (.clk(clk), .rst(rst), .bus(a));
  lzc_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5), .OUT_W(32)) u64 (.clk(clk), .rst(rst), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drv_a(input logic vld, input logic [31:0] d, input logic ones, input logic [4:0] tag);
    a.in_valid = vld;
    a.in_data = d;
    a.in_ones = ones;
    a.in_tag = tag;
  endtask
  task automatic drv_b(input logic vld, input logic [63:0] d, input logic ones, input logic [4:0] tag);
    b.in_valid = vld;
    b.in_data = d;
    b.in_ones = ones;
    b.in_tag = tag;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drv_a(1'b0, '0, 1'b0, '0);
    drv_b(1'b0, '0, 1'b0, '0);
    a.flush = 1'b0;
    b.flush = 1'b0;
    a.out_ready = 1'b1;
    b.out_ready = 1'b1;
`ifdef LZC_PIPE_CTZ_EN
    a.in_trail = 1'b0;
    b.in_trail = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid32", a.out_valid, 0);
    chk("rst_busy32", a.busy, 0);
    chk("rst_count32", a.out_count, 0);
    chk("rst_tag32", a.out_tag, 0);
    chk("rst_ready32", a.in_ready, 1);
    chk("rst_valid64", b.out_valid, 0);
    chk("rst_ready64", b.in_ready, 1);
    drv_a(1'b1, 32'h0001_0000, 1'b0, 5'd7);
    @(negedge clk);
    drv_a(1'b0, '0, 1'b0, '0);
    chk("lat1_valid", a.out_valid, 0);
    chk("lat1_busy", a.busy, 1);
    @(negedge clk);
    chk("lat2_valid", a.out_valid, 1);
    chk("lat2_count", a.out_count, 15);
    chk("lat2_tag", a.out_tag, 7);
    drv_a(1'b1, 32'h8000_0000, 1'b0, 5'd1);
    @(negedge clk);
    drv_a(1'b1, 32'h0000_0000, 1'b0, 5'd2);
    @(negedge clk);
    chk("b2b0_valid", a.out_valid, 1);
    chk("b2b0_count", a.out_count, 0);
    chk("b2b0_tag", a.out_tag, 1);
    drv_a(1'b1, 32'hFFFF_FFFF, 1'b1, 5'd3);
    @(negedge clk);
    drv_a(1'b0, '0, 1'b0, '0);
    chk("b2b1_valid", a.out_valid, 1);
    chk("b2b1_count", a.out_count, 32);
    chk("b2b1_tag", a.out_tag, 2);
    @(negedge clk);
    chk("b2b2_valid", a.out_valid, 1);
    chk("b2b2_count", a.out_count, 32);
    chk("b2b2_tag", a.out_tag, 3);
    @(negedge clk);
    chk("b2b_drain", a.out_valid, 0);
    a.out_ready = 1'b0;
    drv_a(1'b1, 32'h0000_0001, 1'b0, 5'd4);
    @(negedge clk);
    chk("stall_ready1", a.in_ready, 1);
    drv_a(1'b1, 32'h4000_0000, 1'b0, 5'd5);
    @(negedge clk);
    chk("stall_valid", a.out_valid, 1);
    chk("stall_count0", a.out_count, 31);
    chk("stall_tag0", a.out_tag, 4);
    chk("stall_full", a.in_ready, 0);
    drv_a(1'b1, 32'h00FF_0000, 1'b0, 5'd6);
    @(negedge clk);
    chk("stall_count1", a.out_count, 31);
    chk("stall_full1", a.in_ready, 0);
    @(negedge clk);
    chk("stall_count2", a.out_count, 31);
    chk("stall_tag2", a.out_tag, 4);
    a.out_ready = 1'b1;
    #1;
    chk("release_ready", a.in_ready, 1);
    @(negedge clk);
    drv_a(1'b0, '0, 1'b0, '0);
    chk("order1_valid", a.out_valid, 1);
    chk("order1_count", a.out_count, 1);
    chk("order1_tag", a.out_tag, 5);
    @(negedge clk);
    chk("order2_valid", a.out_valid, 1);
    chk("order2_count", a.out_count, 8);
    chk("order2_tag", a.out_tag, 6);
    @(negedge clk);
    chk("order_drain", a.out_valid, 0);
    chk("order_busy", a.busy, 0);
    drv_a(1'b1, 32'h0000_0001, 1'b0, 5'd8);
    @(negedge clk);
    drv_a(1'b1, 32'h0000_0002, 1'b0, 5'd9);
    @(negedge clk);
    chk("preflush_busy", a.busy, 1);
    chk("preflush_valid", a.out_valid, 1);
    a.flush = 1'b1;
    drv_a(1'b1, 32'h0000_0003, 1'b0, 5'd10);
    #1;
    chk("flush_ready", a.in_ready, 0);
    @(negedge clk);
    a.flush = 1'b0;
    drv_a(1'b0, '0, 1'b0, '0);
    chk("flush_valid", a.out_valid, 0);
    chk("flush_busy", a.busy, 0);
    @(negedge clk);
    chk("flush_valid2", a.out_valid, 0);
    chk("flush_busy2", a.busy, 0);
    drv_b(1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1, 5'd11);
    @(negedge clk);
    chk("dclo_valid", b.out_valid, 1);
    chk("dclo_count", b.out_count, 32);
    chk("dclo_tag", b.out_tag, 11);
    drv_b(1'b1, 64'h1, 1'b0, 5'd12);
    @(negedge clk);
    chk("dclz1_count", b.out_count, 63);
    chk("dclz1_tag", b.out_tag, 12);
    drv_b(1'b1, 64'h0, 1'b0, 5'd13);
    @(negedge clk);
    chk("dclz0_count", b.out_count, 64);
    drv_b(1'b1, 64'h5, 1'b0, 5'd14);
    drv_a(1'b1, 32'h0000_0001, 1'b0, 5'd15);
    @(negedge clk);
    chk("dclz5_count", b.out_count, 61);
    chk("mid_busy32", a.busy, 1);
    drv_a(1'b0, '0, 1'b0, '0);
    drv_b(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("arst_valid64", b.out_valid, 0);
    chk("arst_count64", b.out_count, 0);
    chk("arst_busy32", a.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_drop32", a.out_valid, 0);
    chk("arst_drop64", b.out_valid, 0);
`ifdef LZC_PIPE_CTZ_EN
    a.in_trail = 1'b1;
    drv_a(1'b1, 32'h0000_0008, 1'b0, 5'd1);
    @(negedge clk);
    drv_a(1'b1, 32'h0000_000F, 1'b1, 5'd2);
    @(negedge clk);
    drv_a(1'b0, '0, 1'b0, '0);
    a.in_trail = 1'b0;
    chk("ctz_count", a.out_count, 3);
    chk("ctz_tag", a.out_tag, 1);
    @(negedge clk);
    chk("cto_count", a.out_count, 4);
    chk("cto_tag", a.out_tag, 2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lzc_pipe.md
Name: lzc_pipe

Overview:
- Parametrised, pipelined leading-zero / leading-one counter for the ALU/MDU path. Handles 32-bit CLZ/CLO and 64-bit DCLZ/DCLO by parameter.
- Replaces the single-cycle 32-bit combinational counter.
- Adds valid/ready handshake, configurable pipeline depth, tag pass-through and pipeline flush, so the count can sit off the critical path in the execute stage.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- STAGES, 2, pipeline register stages, 1 or 2.
- TAG_W, 5, width of the opaque tag carried alongside the operand (destination register id).
- OUT_W, 32, result width; must be at least log2(WIDTH)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  WIDTH  operand.
- in_ones  in  1  0 = count leading zeros, 1 = count leading ones.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- flush  in  1  discard all in-flight operations (exception/branch kill).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_count  out  OUT_W  count, zero-extended.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset: asynchronous, active-high. rst clears all stage valid bits immediately. out_valid=0, busy=0, out_count=0, out_tag=0. in_ready=1 after reset deasserts.
- Transfer rules: input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
- Arithmetic: v = in_data XOR {WIDTH{in_ones}}. Count = number of consecutive zeros in v from the MSB.
- All-zero v returns WIDTH exactly, e.g. 32 for a 32-bit CLZ of 0 or a CLO of 0xFFFFFFFF.
- Count is formed by binary halving: log2(WIDTH) bisection levels, plus an all-zero detect that drives bit log2(WIDTH).
- STAGES=2:
  - Stage 1 registers v, the tag, the upper ceil(L/2) count bits and the selected residual slice.
  - Stage 2 finishes the lower bits and registers the result.
  - Latency is 2 cycles from input transfer to out_valid.
- STAGES=1: the whole count is registered in one stage; latency 1.
- Throughput: one operation per cycle when out_ready=1.
- Per stage k: ready_k = !valid_k | ready_{k+1}, with ready of the last stage = out_ready. in_ready = ready_1 (combinational through the chain, no bubble).
- Stall: while out_valid=1 and out_ready=0, out_count and out_tag hold stable. No stage with a valid entry is overwritten.
- flush: synchronous. On the next edge every valid bit clears, and any input presented in the flush cycle is not accepted (in_ready forced 0 while flush=1). An output handshaking in the flush cycle is still considered consumed.
- Data registers load only on stage advance. Their contents are don't-care when the matching valid=0, but must be X-free after reset (data registers also reset to 0).
- rst asserted mid-operation drops all in-flight entries with no output.

Optional Feature:
- Macro: LZC_PIPE_CTZ_EN.
- Defined: adds input port in_trail (1 bit). When in_trail=1, the operand bits are reversed before the XOR, so the block counts trailing zeros/ones; all-zero still returns WIDTH. in_trail is pipelined with the operation and does not affect latency.
- Not defined: the port is absent and the behaviour is leading counts only.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1; in_data=0x00010000, in_ones=0, tag=7 → two cycles later out_valid=1, out_count=15, out_tag=7.
- Back-to-back operands 0x80000000, 0x00000000, and 0xFFFFFFFF with in_ones=1, on consecutive cycles → outputs 0, 32, 32 on consecutive cycles, no bubbles.
- Hold out_ready=0 for 3 cycles with 3 ops issued → in_ready falls after the pipe fills (2 entries). out_count stays stable. On release, results emerge in order with no loss or duplication.
- Two ops in flight, assert flush for one cycle with in_valid=1 → no out_valid afterwards, the flushed input is not accepted, busy=0 next cycle.
- WIDTH=64, STAGES=1: DCLO of 0xFFFF_FFFF_0000_0000 → 32 after 1 cycle; DCLZ of 1 → 63; rst pulsed mid-flight → out_valid=0 immediately.
- LZC_PIPE_CTZ_EN defined, in_trail=1: in_data=0x00000008 → 3; in_ones=1 with in_data=0x0000000F → 4.
